// File: rtl/ifetch_defs.sv
// Shared definitions for the instruction-fetch slice: fetch-entry layout,
// exception causes and fetch-state encoding.
package ifetch_defs;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [3:0] EXC_INSTR_MISALIGNED   = 4'd0;
   localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;

   localparam int PC_W       = 64;
   localparam int INSTR_W    = 32;
   localparam int EXC_EN_W   = 1;
   localparam int EXC_CODE_W = 4;
   localparam int EXC_VAL_W  = 64;
   localparam int ENTRY_W    = PC_W + INSTR_W + EXC_EN_W + EXC_CODE_W + EXC_VAL_W;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]       pc;
      logic [INSTR_W-1:0]    instr;
      logic                  exc_en;
      logic [EXC_CODE_W-1:0] exc_code;
      logic [EXC_VAL_W-1:0]  exc_val;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode/execute environment side.
interface ifetch_unit_if;

   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        imem_exc_en;
   logic [3:0]  imem_exc_code;
   logic [63:0] imem_exc_val;

   logic        redirect_en;
   logic [63:0] redirect_pc;

   logic        if_valid;
   logic        if_ready;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_exc_en;
   logic [3:0]  if_exc_code;
   logic [63:0] if_exc_val;
   logic        fetch_halted;

   modport master (
      output imem_addr,
      input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
      input  redirect_en, redirect_pc,
      output if_valid,
      input  if_ready,
      output if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val,
      output fetch_halted
   );

   modport slave (
      input  imem_addr,
      output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
      output redirect_en, redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val,
      input  fetch_halted
   );

endinterface

// File: rtl/ifetch_unit_queue.sv
// ifetch_queue: DEPTH-entry synchronous FIFO of fetch entries with flush and
// simultaneous push/pop on a full queue. Only control state is reset.
module ifetch_queue
   import ifetch_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  fetch_entry_t i_data,
   input  logic         i_pop,
   output fetch_entry_t o_data,
   output logic         o_valid,
   output logic         o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_valid   = (r_count != '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && o_valid && !i_flush;
   assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the fetch PC, queues fetched entries for decode.
// Optional macro IFETCH_MISALIGN_CHECK_EN raises a misaligned-fetch exception.
module ifetch_unit
   import ifetch_defs::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   ifetch_unit_if.master bus
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [63:0]  r_pc;

   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_misalign;
   logic         w_head_vld;
   fetch_entry_t w_entry;
   fetch_entry_t w_head;

   assign bus.imem_addr = r_pc;

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign w_misalign = (r_pc[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_pop  = w_head_vld && bus.if_ready;
   assign w_push = (r_state == ST_RUN) && (!w_full || w_pop) && !bus.redirect_en;

   always_comb begin
      w_entry.pc       = r_pc;
      w_entry.instr    = bus.imem_instr;
      w_entry.exc_en   = bus.imem_exc_en;
      w_entry.exc_code = bus.imem_exc_code;
      w_entry.exc_val  = bus.imem_exc_val;
      if (w_misalign) begin
         w_entry.exc_en   = 1'b1;
         w_entry.exc_code = EXC_INSTR_MISALIGNED;
         w_entry.exc_val  = r_pc;
      end
      if (w_entry.exc_en) begin
         w_entry.instr = NOP_INSTR;
      end
   end

   ifetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.redirect_en),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_head_vld),
      .o_full  (w_full)
   );

   // A faulting fetch keeps the PC on the faulting address
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (bus.redirect_en) begin
         r_pc <= bus.redirect_pc;
      end else if (w_push && !w_entry.exc_en) begin
         r_pc <= r_pc + 64'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.redirect_en) begin
         w_state_nxt = ST_RUN;
      end else if (w_push && w_entry.exc_en) begin
         w_state_nxt = ST_HALT;
      end
   end

   always_comb begin
      bus.fetch_halted = (r_state == ST_HALT);
   end

   always_comb begin
      bus.if_valid    = w_head_vld;
      bus.if_pc       = '0;
      bus.if_instr    = NOP_INSTR;
      bus.if_exc_en   = 1'b0;
      bus.if_exc_code = '0;
      bus.if_exc_val  = '0;
      if (w_head_vld) begin
         bus.if_pc       = w_head.pc;
         bus.if_instr    = w_head.instr;
         bus.if_exc_en   = w_head.exc_en;
         bus.if_exc_code = w_head.exc_code;
         bus.if_exc_val  = w_head.exc_val;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus randomized traffic against
// a queue-based reference model of the fetch unit.
module tb_ifetch_unit;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam int          QD     = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic [3:0]  code;
      logic [63:0] val;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic        redir = 1'b0;
   logic [63:0] rpc = '0;

   logic        flt_on = 1'b0;
   logic [63:0] flt_addr = '0;
   logic        flt_rand = 1'b0;
   logic [4:0]  flt_sel = '0;
   logic [3:0]  flt_code = 4'd1;

   ent_t        mq[$];
   logic [63:0] mpc;
   logic        mhalt;

   int checks = 0;
   int failures = 0;

   ifetch_unit_if bus ();

   ifetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (QD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] off;
      off = {a[31:2], 2'b00} - 32'h8000_0000;
      return (off * 32'h9E37_79B1) ^ 32'h0010_0093;
   endfunction

   function automatic logic mem_exc(input logic [63:0] a, input logic on, input logic [63:0] fa,
                                    input logic rnd, input logic [4:0] sel);
      return (on && a == fa) || (rnd && a[6:2] == sel);
   endfunction

   assign bus.imem_instr    = mem_word(bus.imem_addr);
   assign bus.imem_exc_en   = mem_exc(bus.imem_addr, flt_on, flt_addr, flt_rand, flt_sel);
   assign bus.imem_exc_code = flt_code;
   assign bus.imem_exc_val  = bus.imem_addr;
   assign bus.redirect_en   = redir;
   assign bus.redirect_pc   = rpc;
   assign bus.if_ready      = ready;

   // Compare DUT against model, advance the model by one clock, then clock the DUT
   task automatic step();
      int   n;
      logic pop;
      logic push;
      ent_t e;
      n = mq.size();
      checks++;
      if (bus.if_valid !== (n != 0)) begin
         failures++;
         $display("FAIL if_valid t=%0t got=%b exp=%b", $time, bus.if_valid, (n != 0));
      end
      checks++;
      if (bus.imem_addr !== mpc) begin
         failures++;
         $display("FAIL imem_addr t=%0t got=%h exp=%h", $time, bus.imem_addr, mpc);
      end
      checks++;
      if (bus.fetch_halted !== mhalt) begin
         failures++;
         $display("FAIL fetch_halted t=%0t got=%b exp=%b", $time, bus.fetch_halted, mhalt);
      end
      if (n != 0) begin
         checks++;
         if (bus.if_pc !== mq[0].pc || bus.if_instr !== mq[0].instr || bus.if_exc_en !== mq[0].exc ||
             bus.if_exc_code !== mq[0].code || bus.if_exc_val !== mq[0].val) begin
            failures++;
            $display("FAIL head t=%0t got=%h/%h/%b/%h/%h exp=%h/%h/%b/%h/%h", $time,
                     bus.if_pc, bus.if_instr, bus.if_exc_en, bus.if_exc_code, bus.if_exc_val,
                     mq[0].pc, mq[0].instr, mq[0].exc, mq[0].code, mq[0].val);
         end
      end else begin
         checks++;
         if (bus.if_instr !== NOP || bus.if_pc !== 64'd0 || bus.if_exc_en !== 1'b0) begin
            failures++;
            $display("FAIL empty_head t=%0t got=%h/%h/%b exp=%h/0/0", $time,
                     bus.if_pc, bus.if_instr, bus.if_exc_en, NOP);
         end
      end

      pop = (n != 0) && ready;
      if (redir) begin
         mq.delete();
         mpc   = rpc;
         mhalt = 1'b0;
      end else begin
         push = !mhalt && (n < QD || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.pc    = mpc;
            e.exc   = mem_exc(mpc, flt_on, flt_addr, flt_rand, flt_sel);
            e.code  = flt_code;
            e.val   = mpc;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (mpc[1:0] != 2'b00) begin
               e.exc  = 1'b1;
               e.code = 4'd0;
               e.val  = mpc;
            end
`endif
            e.instr = e.exc ? NOP : mem_word(mpc);
            mq.push_back(e);
            if (e.exc) mhalt = 1'b1;
            else       mpc = mpc + 64'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redir = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      mpc   = RST_PC;
      mhalt = 1'b0;
   endtask

   task automatic do_redirect(input logic [63:0] pc);
      rpc   = pc;
      redir = 1'b1;
      step();
      redir = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.if_valid !== 1'b0 || bus.if_pc !== 64'd0 || bus.if_instr !== NOP ||
          bus.if_exc_en !== 1'b0 || bus.if_exc_code !== 4'd0 || bus.if_exc_val !== 64'd0 ||
          bus.fetch_halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h/%h/%b/%h/%h/%b exp=0/0/%h/0/0/0/0", bus.if_valid,
                  bus.if_pc, bus.if_instr, bus.if_exc_en, bus.if_exc_code, bus.if_exc_val,
                  bus.fetch_halted, NOP);
      end
      checks++;
      if (bus.imem_addr !== RST_PC) begin
         failures++;
         $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, RST_PC);
      end
   endtask

   task automatic test_stream();
      ready = 1'b1;
      step();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8000_0000 || bus.if_instr !== 32'h0010_0093) begin
         failures++;
         $display("FAIL first_fetch got=%b/%h/%h exp=1/80000000/00100093", bus.if_valid, bus.if_pc,
                  bus.if_instr);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.if_pc !== 64'h8000_0000 + 64'(4 * i)) begin
            failures++;
            $display("FAIL stream_pc got=%h exp=%h", bus.if_pc, 64'h8000_0000 + 64'(4 * i));
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (bus.imem_addr !== 64'h8000_0008 || bus.if_pc !== 64'h8000_0000) begin
         failures++;
         $display("FAIL bp_frozen got=%h/%h exp=80000008/80000000", bus.imem_addr, bus.if_pc);
      end
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8000_0000 + 64'(4 * i)) begin
            failures++;
            $display("FAIL bp_order got=%b/%h exp=1/%h", bus.if_valid, bus.if_pc,
                     64'h8000_0000 + 64'(4 * i));
         end
         step();
      end
   endtask

   task automatic test_fault();
      flt_on   = 1'b1;
      flt_addr = 64'h8004_0000;
      flt_code = 4'd1;
      ready    = 1'b1;
      do_redirect(64'h8004_0000);
      step();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_exc_en !== 1'b1 || bus.if_exc_code !== 4'd1 ||
          bus.if_exc_val !== 64'h8004_0000 || bus.if_instr !== NOP || bus.fetch_halted !== 1'b1) begin
         failures++;
         $display("FAIL fault_entry got=%b/%b/%h/%h/%h/%b exp=1/1/1/80040000/%h/1", bus.if_valid,
                  bus.if_exc_en, bus.if_exc_code, bus.if_exc_val, bus.if_instr, bus.fetch_halted, NOP);
      end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (bus.imem_addr !== 64'h8004_0000 || bus.if_valid !== 1'b0 || bus.fetch_halted !== 1'b1) begin
         failures++;
         $display("FAIL fault_hold got=%h/%b/%b exp=80040000/0/1", bus.imem_addr, bus.if_valid,
                  bus.fetch_halted);
      end
      flt_on = 1'b0;
   endtask

   task automatic test_redirect_halt();
      do_redirect(64'h8000_0100);
      checks++;
      if (bus.if_valid !== 1'b0 || bus.fetch_halted !== 1'b0 || bus.imem_addr !== 64'h8000_0100) begin
         failures++;
         $display("FAIL redir_halt got=%b/%b/%h exp=0/0/80000100", bus.if_valid, bus.fetch_halted,
                  bus.imem_addr);
      end
      step();
      checks++;
      if (bus.if_pc !== 64'h8000_0100 || bus.if_valid !== 1'b1) begin
         failures++;
         $display("FAIL redir_resume got=%b/%h exp=1/80000100", bus.if_valid, bus.if_pc);
      end
      step();
   endtask

   task automatic test_redirect_full();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      ready = 1'b1;
      do_redirect(64'h8000_0200);
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== 64'h8000_0200) begin
         failures++;
         $display("FAIL redir_full got=%b/%h exp=0/80000200", bus.if_valid, bus.imem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8000_0200 + 64'(4 * i)) begin
            failures++;
            $display("FAIL redir_rate got=%b/%h exp=1/%h", bus.if_valid, bus.if_pc,
                     64'h8000_0200 + 64'(4 * i));
         end
      end
   endtask

   task automatic test_wrap();
      ready = 1'b1;
      do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
      step();
      step();
      step();
      checks++;
      if (bus.if_pc !== 64'd0 || bus.imem_addr !== 64'd4) begin
         failures++;
         $display("FAIL pc_wrap got=%h/%h exp=0/4", bus.if_pc, bus.imem_addr);
      end
      step();
   endtask

   task automatic test_misalign();
      ready = 1'b1;
      do_redirect(64'h8000_0102);
      step();
`ifdef IFETCH_MISALIGN_CHECK_EN
      checks++;
      if (bus.if_exc_en !== 1'b1 || bus.if_exc_code !== 4'd0 || bus.if_exc_val !== 64'h8000_0102 ||
          bus.fetch_halted !== 1'b1) begin
         failures++;
         $display("FAIL misalign got=%b/%h/%h/%b exp=1/0/80000102/1", bus.if_exc_en, bus.if_exc_code,
                  bus.if_exc_val, bus.fetch_halted);
      end
`else
      checks++;
      if (bus.if_pc !== 64'h8000_0102 || bus.if_instr !== mem_word(64'h8000_0100) ||
          bus.if_exc_en !== 1'b0) begin
         failures++;
         $display("FAIL misalign_off got=%h/%h/%b exp=80000102/%h/0", bus.if_pc, bus.if_instr,
                  bus.if_exc_en, mem_word(64'h8000_0100));
      end
`endif
      step();
      do_redirect(64'h8000_0400);
   endtask

   task automatic test_mid_reset();
      ready = 1'b0;
      step();
      step();
      do_reset();
      checks++;
      if (bus.if_valid !== 1'b0 || bus.imem_addr !== RST_PC) begin
         failures++;
         $display("FAIL mid_reset got=%b/%h exp=0/%h", bus.if_valid, bus.imem_addr, RST_PC);
      end
      step();
   endtask

   task automatic test_random();
      logic [63:0] pc;
      flt_rand = 1'b1;
      flt_sel  = 5'd13;
      for (int i = 0; i < 600; i++) begin
         ready    = ($urandom_range(0, 3) != 0);
         flt_code = 4'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
            if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom);
            flt_sel = 5'($urandom);
            do_redirect(pc);
         end else if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end
      flt_rand = 1'b0;
   endtask

   initial begin
      mq.delete();
      mpc   = RST_PC;
      mhalt = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_fault();
      test_redirect_halt();
      test_redirect_full();
      test_wrap();
      test_misalign();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch initiator that drives the PC-indexed instruction memory port and consumes its word and access-fault response. It sits between the instruction memory and the decode stage. It owns the architectural fetch PC and buffers fetched {pc, instr, exception} entries in a small queue. It presents those entries to decode over a valid/ready handshake, and accepts redirects from execute or the trap logic.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- DEPTH, 2, fetch-queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset
- imem_addr  out  64  fetch address to instruction memory (combinational read)
- imem_instr  in  32  instruction word at imem_addr
- imem_exc_en  in  1  access fault for imem_addr
- imem_exc_code  in  4  fault cause
- imem_exc_val  in  64  fault value (bad PC)
- redirect_en  in  1  flush and restart fetch
- redirect_pc  in  64  new fetch PC
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_pc  out  64  head PC
- if_instr  out  32  head instruction
- if_exc_en  out  1  head carries exception
- if_exc_code  out  4  head exception cause
- if_exc_val  out  64  head exception value
- fetch_halted  out  1  fetch stopped after a fault, waiting for redirect

Behaviour:
- Reset is synchronous, active-high, on rst. On reset: pc=RESET_PC, queue empty, state RUN.
  - Outputs: if_valid=0, if_pc=0, if_instr=32'h00000013, if_exc_en=0, if_exc_code=0, if_exc_val=0, fetch_halted=0.
  - rst asserted mid-operation discards all queued entries.
- imem_addr = pc register at all times. The memory response is sampled in the same cycle.
- States:
  - RUN: fetching.
  - HALT: fault entry queued; no further pushes.
- push = (state==RUN) && (count<DEPTH || pop) && !redirect_en.
- pop = if_valid && if_ready.
- On push:
  - Enqueue {pc, imem_instr, imem_exc_en, imem_exc_code, imem_exc_val}.
  - If imem_exc_en: the enqueued instruction is forced to NOP 32'h00000013, state→HALT, pc unchanged.
  - Otherwise pc←pc+4, modulo 2^64 (wraps to 0).
- Latency: address presented in cycle N appears at the queue head, with if_valid=1, in cycle N+1 when the queue was empty. Steady state is one instruction per cycle while if_ready=1.
- Full queue with pop in the same cycle: push and pop both occur, count unchanged.
- Full queue without pop: no push, pc held.
- Head outputs are held stable while if_valid && !if_ready.
- redirect_en has highest priority:
  - Queue flushed (count←0) and pc←redirect_pc; state→RUN.
  - No push that cycle.
  - A head presented in the redirect cycle is discarded regardless of if_ready.
  - if_valid=0 in the following cycle.
- In HALT, queued entries still drain normally. fetch_halted=1 while state==HALT.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- When empty: if_valid=0 and if_instr=NOP.

Optional Feature:
Macro IFETCH_MISALIGN_CHECK_EN.
- Defined: if pc[1:0]!=0 at push time, the imem response is ignored. Instead enqueue instr=NOP, exc_en=1, exc_code=0 (instruction address misaligned), exc_val=pc, and state→HALT.
- Undefined: pc[1:0] is not checked; the memory word-indexes the address.

Decomposition:
- Shared package/include ifetch_defs holds:
  - NOP_INSTR=32'h00000013
  - EXC_INSTR_MISALIGNED=4'd0 and EXC_INSTR_ACCESS_FAULT=4'd1
  - fetch-entry field widths and total entry width (64+32+1+4+64=165)
  - state encodings RUN=1'b0 and HALT=1'b1
- One sub-module: ifetch_queue, a DEPTH-entry synchronous FIFO with flush and simultaneous push/pop. The PC/state logic stays in ifetch_unit.

Test Plan:
- Reset, then release with if_ready=1 and memory returning 0x00100093 at 0x80000000 → cycle 1: if_valid=1, if_pc=0x80000000, if_instr=0x00100093. Next cycles give if_pc +4 each.
- Hold if_ready=0 for 5 cycles → count reaches 2, imem_addr frozen at 0x80000008, head outputs stable. Then if_ready=1 → entries 0x80000000, 0x80000004, 0x80000008 appear in order, none lost.
- imem_exc_en=1 (code 1, val=0x80040000) at pc=0x80040000 → entry with if_exc_en=1, if_exc_code=1, if_exc_val=0x80040000, if_instr=NOP. fetch_halted=1, imem_addr stays 0x80040000, no further pushes.
- From the halt above, pulse redirect_en with redirect_pc=0x80000100 → queue flushed, fetch_halted=0, next if_pc=0x80000100.
- Full queue with redirect_en=1 and if_ready=1 in the same cycle → next cycle if_valid=0, pc=redirect_pc. Then resume at one instruction per cycle.
- With IFETCH_MISALIGN_CHECK_EN defined, redirect to 0x80000102 → entry if_exc_en=1, if_exc_code=0, if_exc_val=0x80000102, fetch_halted=1. Without the macro, if_pc=0x80000102 with the memory word.
